// File: rtl/fxp_mul_seq_if.sv
// Request/result bundle of the sequential fixed-point multiplier.
// The master drives operands and start. The slave returns status and the product.
interface fxp_mul_seq_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  start;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  ready;
  logic                  complete;
  logic [DATA_WIDTH-1:0] out;
  logic                  overflow;

  modport master (
    output start, a, b,
    input  ready, complete, out, overflow
  );

  modport slave (
    input  start, a, b,
    output ready, complete, out, overflow
  );
endinterface

// File: rtl/fxp_mul_seq.sv
// Sequential signed Q-format multiplier: sign-magnitude shift-add, one bit of |b| per clock,
// with the product truncated toward zero and then saturated to DATA_WIDTH bits.
module fxp_mul_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int BIN_POS    = 8
) (
  input  logic              clk,
  input  logic              rst,
  fxp_mul_seq_if.slave      io_bus
);

  localparam int ACC_W = 2 * DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);

  localparam logic [ACC_W-1:0] MAX_POS_MAG = {{(DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic [ACC_W-1:0] MAX_NEG_MAG = MAX_POS_MAG + ACC_W'(1);
  localparam logic [DATA_WIDTH-1:0] SAT_POS = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_NEG = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [ACC_W-1:0]      r_acc;
  logic [ACC_W-1:0]      r_magA;
  logic [DATA_WIDTH-1:0] r_magB;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_signNeg;
  logic                  r_ready;
  logic                  r_complete;
  logic [DATA_WIDTH-1:0] r_out;
  logic                  r_overflow;

  logic [DATA_WIDTH-1:0] w_magA;
  logic [DATA_WIDTH-1:0] w_magB;
  logic                  w_accept;
  logic                  w_lastStep;
  logic [ACC_W-1:0]      w_accNext;
  logic [ACC_W-1:0]      w_mag;
  logic [DATA_WIDTH-1:0] w_res;
  logic                  w_ovf;

  // The most negative operand negates to itself, which is exactly its unsigned magnitude.
  assign w_magA = io_bus.a[DATA_WIDTH-1] ? (DATA_WIDTH'(0) - io_bus.a) : io_bus.a;
  assign w_magB = io_bus.b[DATA_WIDTH-1] ? (DATA_WIDTH'(0) - io_bus.b) : io_bus.b;

  assign w_accept   = io_bus.start & r_ready;
  assign w_lastStep = (r_cnt == CNT_W'(DATA_WIDTH - 1));
  assign w_accNext  = r_magB[0] ? (r_acc + r_magA) : r_acc;
  assign w_mag      = w_accNext >> BIN_POS;

  // Saturation bounds are asymmetric: a negative result may reach one step further than a positive one.
  always_comb begin
    w_res = w_mag[DATA_WIDTH-1:0];
    w_ovf = 1'b0;
    if (!r_signNeg) begin
      if (w_mag > MAX_POS_MAG) begin
        w_res = SAT_POS;
        w_ovf = 1'b1;
      end
    end else begin
      if (w_mag > MAX_NEG_MAG) begin
        w_res = SAT_NEG;
        w_ovf = 1'b1;
      end else begin
        w_res = DATA_WIDTH'(0) - w_mag[DATA_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_magA     <= '0;
      r_magB     <= '0;
      r_cnt      <= '0;
      r_signNeg  <= 1'b0;
      r_ready    <= 1'b1;
      r_complete <= 1'b0;
      r_out      <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_BUSY: begin
          r_acc  <= w_accNext;
          r_magA <= r_magA << 1;
          r_magB <= r_magB >> 1;
          r_cnt  <= r_cnt + CNT_W'(1);
          if (w_lastStep) begin
            r_state    <= S_DONE;
            r_ready    <= 1'b1;
            r_complete <= 1'b1;
            r_out      <= w_res;
            r_overflow <= w_ovf;
          end
        end
        default: begin
          // IDLE and DONE both accept; DONE keeps its result until the next accept.
          if (w_accept) begin
            r_state    <= S_BUSY;
            r_acc      <= '0;
            r_magA     <= {{DATA_WIDTH{1'b0}}, w_magA};
            r_magB     <= w_magB;
            r_cnt      <= '0;
            r_signNeg  <= io_bus.a[DATA_WIDTH-1] ^ io_bus.b[DATA_WIDTH-1];
            r_ready    <= 1'b0;
            r_complete <= 1'b0;
          end
        end
      endcase
    end
  end

  assign io_bus.ready    = r_ready;
  assign io_bus.complete = r_complete;
  assign io_bus.out      = r_out;
  assign io_bus.overflow = r_overflow;

endmodule
